bls12_381_fe2_addsub_resp: RTL and testbench
============================================

// Module: bls12_381_fe2_addsub_resp
//
// PURPOSE
//  Responder for the FE2 (mod P) adder and subtractor streams that the pairing/Miller-loop
//  sequencers drive. Accepts tagged {b,a} operand pairs on two AXI-stream sinks (add, sub),
//  computes per-component (a+b) mod P or (a-b) mod P, and returns the result with the request
//  ctl unchanged on the matching source. One shared 3-stage pipeline serves both streams.
//
// PARAMETERS
//  FE_TYPE   -  (required)  Fp element type, 381 bits
//  FE2_TYPE  -  (required)  Fp2 element type, [1:0] of FE_TYPE
//  P         -  bls12_381_pkg::P  field modulus
//  CTL_BITS  -  16  width of ctl passed through untouched
//
// PORTS
//  i_clk       in   1                  clock
//  i_rst       in   1                  synchronous, active-high reset
//  i_add_if    sink if_axi_stream      add requests: dat[0+:F2]=a, dat[F2+:F2]=b (F2=$bits(FE2_TYPE))
//  i_sub_if    sink if_axi_stream      sub requests, same packing, result a-b
//  o_add_if    src  if_axi_stream      add results: dat[0+:F2], ctl copied
//  o_sub_if    src  if_axi_stream      sub results: dat[0+:F2], ctl copied
//  o_err       out  1                  sticky operand-range error (see CONFIGURATION)
//
// BEHAVIOUR
//  - Reset: all o_*.val/dat/ctl/err = 0, sop=eop=1, mod=0, i_*.rdy=0, o_err=0, RR pointer=add.
//    Reset mid-operation discards every in-flight request; nothing is emitted afterwards.
//  - Pipeline S1 (raw op) -> S2 (mod correction) -> S3 (output regs). Advance when S3 empty or
//    the S3-routed source has rdy. Stall freezes all stages; no loss, no duplication.
//  - i_*.rdy = advance && granted. At most one request accepted per cycle.
//  - Arbitration: only one valid -> grant it. Both valid -> grant by RR pointer; pointer
//    toggles to the other stream after every grant on a tie. Starvation-free.
//  - S1 per component c: add s=a[c]+b[c] (382b); sub s=a[c]-b[c] with borrow bit.
//  - S2: add -> s>=P ? s-P : s; sub -> borrow ? s+P : s. Result truncated to 381b.
//  - S3: result to o_add_if if op=add else o_sub_if; only that source's val asserts.
//    val held until rdy (val && rdy = transfer). ctl, op tag carried in every stage.
//  - Latency: handshake on edge N -> o_*.val high after edge N+2 (3 cycles); throughput 1/clk.
//  - Results leave in acceptance order across both streams; per-stream order preserved.
//  - Operands assumed < P; a+b=P -> 0; (P-1)+(P-1) -> P-2; a<b sub wraps by +P.
//  - o_*.err = 0 and o_*.mod = 0 always, unless CONFIGURATION enables the range check.
//  - Unknown combinations (both sinks' val low) leave stages bubbling; bubbles carry val=0.
//
// CONFIGURATION
//  BLS12_381_FE2_ADDSUB_RANGE_CHK_EN
//   defined: S1 flags any component of a or b >= P; result still computed, the result beat
//            has o_*.err=1, and o_err sets sticky until i_rst.
//   undefined: no comparators; o_*.err=0, o_err tied 0.
//
// TESTING
//  1 add a=(1,2) b=(3,4) ctl=5 -> o_add_if dat=(4,6) ctl=5, val 3 cycles after handshake
//  2 add a=(P-1,P-1) b=(1,2) -> (0,1); add (P-1,P-1)+(P-1,P-1) -> (P-2,P-2)
//  3 sub a=(0,5) b=(1,2) ctl=9 -> o_sub_if dat=(P-1,3) ctl=9; o_add_if.val stays 0
//  4 add+sub val both high for 4 reqs each, ctl 0..7 -> grants A,S,A,S..; each source gets
//    its 4 results in order, ctls intact, 1 result/clk
//  5 pipeline full, o_add_if.rdy low 10 clks -> S3 held, i_*.rdy low, then all results once
//  6 (RANGE_CHK_EN) add a=(P,0) b=(0,0) -> beat err=1, o_err=1 until i_rst; i_rst mid-stream
//    with 3 in flight -> no val for 5 clks after reset release

Source files
------------

// File: rtl/bls12_381_fe2_addsub_resp_if.sv
// AXI-stream style handshake bundle shared by the FE2 add/sub request and result ports.
// master drives the beat (val/dat/ctl/sop/eop/err/mod) and samples rdy; slave is the reverse.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 8,
    parameter int unsigned CTL_BITS = 16,
    parameter int unsigned MOD_BITS = 1
) ();
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;

    modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/bls12_381_fe2_addsub_resp.sv
// FE2 (mod P) add/sub responder: two request streams share one 3-stage pipeline
// (raw op -> modular correction -> output registers). Results return on the source
// matching the request stream with ctl unchanged, in acceptance order.
// Optional feature: define BLS12_381_FE2_ADDSUB_RANGE_CHK_EN to flag operands >= P
// (per-beat err plus sticky o_err); undefined, err outputs stay 0.
module bls12_381_fe2_addsub_resp #(
    parameter type             FE_TYPE  = logic [380:0],
    parameter type             FE2_TYPE = logic [1:0][380:0],
    parameter logic [380:0]    P        = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
    parameter int unsigned     CTL_BITS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    if_axi_stream.slave  i_add_if,
    if_axi_stream.slave  i_sub_if,
    if_axi_stream.master o_add_if,
    if_axi_stream.master o_sub_if,
    output logic        o_err
);
    localparam int unsigned W  = $bits(FE_TYPE);
    localparam int unsigned F2 = $bits(FE2_TYPE);

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

    op_e                 rr_ptr;
    logic                grant_add;
    logic                grant_sub;
    logic                advance;
    logic [2*F2-1:0]     sel_dat;
    logic [1:0][W:0]     raw;
    logic                range_bad;

    logic                s1_val;
    op_e                 s1_op;
    logic [CTL_BITS-1:0] s1_ctl;
    logic [1:0][W:0]     s1_sum;
    logic                s1_err;

    logic [1:0][W:0]     diff;
    logic [1:0][W-1:0]   wrap;
    logic [1:0][W-1:0]   corr;

    logic                s2_val;
    op_e                 s2_op;
    logic [CTL_BITS-1:0] s2_ctl;
    logic [1:0][W-1:0]   s2_res;
    logic                s2_err;

    logic                unused_ok;

    assign unused_ok = ^{i_add_if.sop, i_add_if.eop, i_add_if.err, i_add_if.mod,
                         i_sub_if.sop, i_sub_if.eop, i_sub_if.err, i_sub_if.mod};

    assign o_add_if.sop = 1'b1;
    assign o_add_if.eop = 1'b1;
    assign o_add_if.mod = '0;
    assign o_sub_if.sop = 1'b1;
    assign o_sub_if.eop = 1'b1;
    assign o_sub_if.mod = '0;

    // Whole pipeline moves only when the occupied output register can drain.
    assign advance   = !(o_add_if.val && !o_add_if.rdy) && !(o_sub_if.val && !o_sub_if.rdy);
    assign grant_add = i_add_if.val && (!i_sub_if.val || rr_ptr == OP_ADD);
    assign grant_sub = i_sub_if.val && (!i_add_if.val || rr_ptr == OP_SUB);
    assign i_add_if.rdy = advance && grant_add && !i_rst;
    assign i_sub_if.rdy = advance && grant_sub && !i_rst;

    // S1 input: raw per-component sum or difference (top bit = carry/borrow), optional range flag.
    always_comb begin
        sel_dat   = grant_sub ? i_sub_if.dat[2*F2-1:0] : i_add_if.dat[2*F2-1:0];
        raw       = '0;
        range_bad = 1'b0;
        for (int unsigned c = 0; c < 2; c++) begin
            if (grant_sub)
                raw[c] = {1'b0, sel_dat[c*W +: W]} - {1'b0, sel_dat[F2 + c*W +: W]};
            else
                raw[c] = {1'b0, sel_dat[c*W +: W]} + {1'b0, sel_dat[F2 + c*W +: W]};
`ifdef BLS12_381_FE2_ADDSUB_RANGE_CHK_EN
            if (sel_dat[c*W +: W] >= P || sel_dat[F2 + c*W +: W] >= P)
                range_bad = 1'b1;
`endif
        end
    end

    // S2 input: fold the raw result back into [0, P).
    always_comb begin
        diff = '0;
        wrap = '0;
        corr = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            diff[c] = s1_sum[c] - {1'b0, P};
            wrap[c] = s1_sum[c][W-1:0] + P;
            if (s1_op == OP_SUB)
                corr[c] = s1_sum[c][W] ? wrap[c] : s1_sum[c][W-1:0];
            else
                corr[c] = (s1_sum[c] >= {1'b0, P}) ? diff[c][W-1:0] : s1_sum[c][W-1:0];
        end
    end

    // Arbitration pointer, pipeline stages and routed output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr       <= OP_ADD;
            s1_val       <= 1'b0;
            s1_op        <= OP_ADD;
            s1_ctl       <= '0;
            s1_sum       <= '0;
            s1_err       <= 1'b0;
            s2_val       <= 1'b0;
            s2_op        <= OP_ADD;
            s2_ctl       <= '0;
            s2_res       <= '0;
            s2_err       <= 1'b0;
            o_add_if.val <= 1'b0;
            o_add_if.dat <= '0;
            o_add_if.ctl <= '0;
            o_add_if.err <= 1'b0;
            o_sub_if.val <= 1'b0;
            o_sub_if.dat <= '0;
            o_sub_if.ctl <= '0;
            o_sub_if.err <= 1'b0;
            o_err        <= 1'b0;
        end else if (advance) begin
            if (i_add_if.val && i_sub_if.val)
                rr_ptr <= (rr_ptr == OP_ADD) ? OP_SUB : OP_ADD;
            s1_val <= grant_add || grant_sub;
            s1_op  <= grant_sub ? OP_SUB : OP_ADD;
            s1_ctl <= grant_sub ? i_sub_if.ctl : i_add_if.ctl;
            s1_sum <= raw;
            s1_err <= range_bad;
            s2_val <= s1_val;
            s2_op  <= s1_op;
            s2_ctl <= s1_ctl;
            s2_res <= corr;
            s2_err <= s1_err;
            o_add_if.val <= s2_val && (s2_op == OP_ADD);
            o_sub_if.val <= s2_val && (s2_op == OP_SUB);
            if (s2_val && s2_op == OP_ADD) begin
                o_add_if.dat <= s2_res;
                o_add_if.ctl <= s2_ctl;
                o_add_if.err <= s2_err;
            end
            if (s2_val && s2_op == OP_SUB) begin
                o_sub_if.dat <= s2_res;
                o_sub_if.ctl <= s2_ctl;
                o_sub_if.err <= s2_err;
            end
`ifdef BLS12_381_FE2_ADDSUB_RANGE_CHK_EN
            if (s2_val && s2_err)
                o_err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_bls12_381_fe2_addsub_resp.sv
// Self-checking bench for bls12_381_fe2_addsub_resp: directed corner cases plus random
// traffic scored against a modular-arithmetic reference model and per-stream queues.
module tb_bls12_381_fe2_addsub_resp;
    localparam int unsigned W   = 381;
    localparam int unsigned F2  = 2 * W;
    localparam int unsigned CTL = 16;
    localparam logic [W-1:0] P  = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
`ifdef BLS12_381_FE2_ADDSUB_RANGE_CHK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]   a0, a1, b0, b1;
        logic [CTL-1:0] ctl;
    } req_t;

    typedef struct {
        logic [F2-1:0]  dat;
        logic [CTL-1:0] ctl;
        logic           err;
        int unsigned    seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    req_t        req_add[$];
    req_t        req_sub[$];
    exp_t        exp_add[$];
    exp_t        exp_sub[$];
    int unsigned acc_stream[$];
    int unsigned acc_seq = 0;
    int unsigned out_seq = 0;
    int unsigned n_out_add = 0;
    int unsigned n_out_sub = 0;

    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BITS(2*F2), .CTL_BITS(CTL)) add_in  ();
    if_axi_stream #(.DAT_BITS(2*F2), .CTL_BITS(CTL)) sub_in  ();
    if_axi_stream #(.DAT_BITS(F2),   .CTL_BITS(CTL)) add_out ();
    if_axi_stream #(.DAT_BITS(F2),   .CTL_BITS(CTL)) sub_out ();

    bls12_381_fe2_addsub_resp #(.CTL_BITS(CTL)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_add_if (add_in),
        .i_sub_if (sub_in),
        .o_add_if (add_out),
        .o_sub_if (sub_out),
        .o_err    (err)
    );

    task automatic check_eq(input string tag, input logic [F2-1:0] got, input logic [F2-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] fe_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+1:0] t;
        t = ({2'b00, a} + {2'b00, b}) % {2'b00, P};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] fe_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+1:0] t;
        t = ({2'b00, a} + {2'b00, P} - {2'b00, b}) % {2'b00, P};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [383:0] r;
        logic [383:0] m;
        r = '0;
        case ($urandom_range(0, 7))
            0: return '0;
            1: return P - 381'd1;
            2: return 381'd1;
            default: begin
                for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
                m = r % {3'b000, P};
                return m[W-1:0];
            end
        endcase
    endfunction

    task automatic push(input int unsigned s, input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [CTL-1:0] ctl);
        req_t r;
        r.a0 = a0; r.a1 = a1; r.b0 = b0; r.b1 = b1; r.ctl = ctl;
        if (s == 0) req_add.push_back(r);
        else req_sub.push_back(r);
    endtask

    task automatic accept(input int unsigned s);
        req_t r;
        exp_t e;
        if (s == 0) begin
            r = req_add.pop_front();
            e.dat = {fe_add(r.a1, r.b1), fe_add(r.a0, r.b0)};
        end else begin
            r = req_sub.pop_front();
            e.dat = {fe_sub(r.a1, r.b1), fe_sub(r.a0, r.b0)};
        end
        e.ctl = r.ctl;
        e.err = RANGE_EN && (r.a0 >= P || r.a1 >= P || r.b0 >= P || r.b1 >= P);
        e.seq = acc_seq;
        acc_seq++;
        if (s == 0) exp_add.push_back(e);
        else exp_sub.push_back(e);
        acc_stream.push_back(s);
    endtask

    task automatic take(input int unsigned s);
        exp_t           e;
        logic [F2-1:0]  d;
        logic [CTL-1:0] c;
        logic           r;
        if (s == 0) begin
            d = add_out.dat; c = add_out.ctl; r = add_out.err; n_out_add++;
            if (exp_add.size() == 0) begin check_eq("add_extra_beat", 1, 0); return; end
            e = exp_add.pop_front();
        end else begin
            d = sub_out.dat; c = sub_out.ctl; r = sub_out.err; n_out_sub++;
            if (exp_sub.size() == 0) begin check_eq("sub_extra_beat", 1, 0); return; end
            e = exp_sub.pop_front();
        end
        check_eq(s == 0 ? "add_dat" : "sub_dat", d, e.dat);
        check_eq(s == 0 ? "add_ctl" : "sub_ctl", c, e.ctl);
        check_eq(s == 0 ? "add_err" : "sub_err", r, e.err);
        check_eq("accept_order", out_seq, e.seq);
        out_seq = e.seq + 1;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_add.size() == 0 && req_sub.size() == 0 && exp_add.size() == 0 && exp_sub.size() == 0)
                break;
        end
        check_eq("drain_in_time", i < budget, 1);
    endtask

    // Request driver: present queue heads after each edge, note acceptances mid-cycle.
    initial begin : driver
        add_in.val = 1'b0; add_in.sop = 1'b1; add_in.eop = 1'b1; add_in.err = 1'b0;
        add_in.mod = '0;   add_in.dat = '0;   add_in.ctl = '0;
        sub_in.val = 1'b0; sub_in.sop = 1'b1; sub_in.eop = 1'b1; sub_in.err = 1'b0;
        sub_in.mod = '0;   sub_in.dat = '0;   sub_in.ctl = '0;
        forever begin
            @(posedge clk);
            #1;
            if (req_add.size() > 0) begin
                add_in.val = 1'b1;
                add_in.dat = {req_add[0].b1, req_add[0].b0, req_add[0].a1, req_add[0].a0};
                add_in.ctl = req_add[0].ctl;
            end else add_in.val = 1'b0;
            if (req_sub.size() > 0) begin
                sub_in.val = 1'b1;
                sub_in.dat = {req_sub[0].b1, req_sub[0].b0, req_sub[0].a1, req_sub[0].a0};
                sub_in.ctl = req_sub[0].ctl;
            end else sub_in.val = 1'b0;
            @(negedge clk);
            if (!rst) begin
                if (add_in.val && sub_in.val) check_eq("one_grant", add_in.rdy && sub_in.rdy, 0);
                if (add_in.val && add_in.rdy) accept(0);
                if (sub_in.val && sub_in.rdy) accept(1);
            end
        end
    end

    // Result monitor: score every transfer against the model queues.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (add_out.val || sub_out.val) check_eq("one_source", add_out.val && sub_out.val, 0);
                if (add_out.val && add_out.rdy) take(0);
                if (sub_out.val && sub_out.rdy) take(1);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned    start;
        int unsigned    lat;
        int unsigned    cnt;
        int unsigned    n0;
        logic [F2-1:0]  want;
        logic [W-1:0]   pm1;
        add_out.rdy = 1'b1;
        sub_out.rdy = 1'b1;
        pm1 = P - 381'd1;

        // reset values, with a request pending on the add sink
        push(0, 381'd1, 381'd2, 381'd3, 381'd4, 16'd1);
        repeat (3) @(negedge clk);
        check_eq("rst_in_rdy", add_in.rdy, 0);
        check_eq("rst_add_val", add_out.val, 0);
        check_eq("rst_sub_val", sub_out.val, 0);
        check_eq("rst_add_dat", add_out.dat, 0);
        check_eq("rst_add_ctl", add_out.ctl, 0);
        check_eq("rst_add_sop", add_out.sop, 1);
        check_eq("rst_sub_eop", sub_out.eop, 1);
        check_eq("rst_add_mod", add_out.mod, 0);
        check_eq("rst_add_err", add_out.err, 0);
        check_eq("rst_o_err", err, 0);
        req_add.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // add (1,2)+(3,4), latency
        push(0, 381'd1, 381'd2, 381'd3, 381'd4, 16'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (add_in.val && add_in.rdy) break;
        end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (add_out.val) break;
        end
        check_eq("t1_latency", lat, 3);
        want = {381'd6, 381'd4};
        check_eq("t1_dat", add_out.dat, want);
        check_eq("t1_ctl", add_out.ctl, 16'd5);
        wait_drain(100);

        // add wrap boundaries
        push(0, pm1, pm1, 381'd1, 381'd2, 16'h11);
        push(0, pm1, pm1, pm1, pm1, 16'h12);
        wait_drain(100);

        // sub with borrow, add source quiet
        push(1, 381'd0, 381'd5, 381'd1, 381'd2, 16'd9);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sub_out.val) break;
        end
        want = {381'd3, pm1};
        check_eq("t3_dat", sub_out.dat, want);
        check_eq("t3_add_quiet", add_out.val, 0);
        wait_drain(100);

        // simultaneous streams: alternating grants, back-to-back results
        start = acc_stream.size();
        for (int k = 0; k < 4; k++) begin
            push(0, rand_fe(), rand_fe(), rand_fe(), rand_fe(), CTL'(2*k));
            push(1, rand_fe(), rand_fe(), rand_fe(), rand_fe(), CTL'(2*k+1));
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (add_out.val || sub_out.val) break;
        end
        cnt = (add_out.val || sub_out.val) ? 1 : 0;
        repeat (7) begin
            @(negedge clk);
            if (add_out.val || sub_out.val) cnt++;
        end
        check_eq("t4_throughput", cnt, 8);
        wait_drain(100);
        for (int k = 0; k < 8; k++) check_eq("t4_grant", acc_stream[start+k], k % 2);

        // back-pressure on the add source
        @(posedge clk);
        #1 add_out.rdy = 1'b0;
        start = acc_stream.size();
        n0 = n_out_add;
        for (int k = 0; k < 6; k++) push(0, rand_fe(), rand_fe(), rand_fe(), rand_fe(), CTL'(16'h100 + k));
        repeat (15) @(negedge clk);
        check_eq("t5_accepted", acc_stream.size() - start, 3);
        check_eq("t5_in_rdy", add_in.rdy, 0);
        check_eq("t5_out_val", add_out.val, 1);
        @(posedge clk);
        #1 add_out.rdy = 1'b1;
        wait_drain(100);
        check_eq("t5_count", n_out_add - n0, 6);

        // random traffic with random back-pressure
        for (int k = 0; k < 40; k++)
            push($urandom_range(0, 1), rand_fe(), rand_fe(), rand_fe(), rand_fe(), CTL'($urandom));
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            add_out.rdy = ($urandom_range(0, 3) != 0);
            sub_out.rdy = ($urandom_range(0, 3) != 0);
            if (req_add.size() == 0 && req_sub.size() == 0 && exp_add.size() == 0 && exp_sub.size() == 0)
                break;
        end
        add_out.rdy = 1'b1;
        sub_out.rdy = 1'b1;
        wait_drain(100);

        // out-of-range operand
        push(0, P, 381'd0, 381'd0, 381'd0, 16'h77);
        wait_drain(100);
        check_eq("t6_o_err", err, RANGE_EN);
        repeat (5) @(negedge clk);
        check_eq("t6_o_err_hold", err, RANGE_EN);

        // reset with requests in flight
        start = acc_stream.size();
        for (int k = 0; k < 6; k++) push(0, rand_fe(), rand_fe(), rand_fe(), rand_fe(), CTL'(k));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_stream.size() - start >= 3) break;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        req_add.delete();
        req_sub.delete();
        exp_add.delete();
        exp_sub.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_seq = acc_seq;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (add_out.val || sub_out.val) cnt++;
        end
        check_eq("t7_quiet_after_rst", cnt, 0);
        check_eq("t7_o_err_cleared", err, 0);

        // traffic still flows after reset
        push(1, pm1, 381'd7, 381'd2, pm1, 16'h55);
        push(0, pm1, 381'd7, 381'd2, pm1, 16'h56);
        wait_drain(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
